datapath_sequencer: RTL and testbench
=====================================

Name: datapath_sequencer

Overview:
Multi-cycle control sequencer for the register-file / ALU / 64x32 RAM datapath. It accepts one command at a time (ALU, LOAD, STORE or NOP) over a valid/ready handshake. It then drives the datapath control pins (rs, rt, rd, ALU_OP, Write_Reg, Mem_Write, wr_data_s) through EXEC, MEM and WB steps. It also captures the ALU status flags. It replaces the hand-driven control sequences currently applied to the datapath.

Parameters:
REG_AW, 5, register-file address width (rs/rt/rd)
OP_W, 3, ALU_OP width
ALU_ADD, 3'b100, ALU_OP code used for address calculation (LOAD/STORE)

Ports:
clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_type  in  2  00 ALU, 01 LOAD, 10 STORE, 11 NOP
cmd_alu_op  in  OP_W  ALU operation (used for ALU type only)
cmd_rs  in  REG_AW  source A register
cmd_rt  in  REG_AW  source B register / store data register
cmd_rd  in  REG_AW  destination register
ZF  in  1  datapath zero flag (combinational from ALU)
OF  in  1  datapath overflow flag (combinational from ALU)
rs  out  REG_AW  to datapath R_Addr_A
rt  out  REG_AW  to datapath R_Addr_B
rd  out  REG_AW  to datapath W_Addr
ALU_OP  out  OP_W  to datapath ALU
Write_Reg  out  1  register-file write enable
Mem_Write  out  1  RAM write enable
wr_data_s  out  2  W_Data select: 00 ALU F, 01 RAM M_R_Data
done  out  1  one-cycle pulse: command complete
busy  out  1  ~cmd_ready
flag_z  out  1  ZF captured by the last ALU command
flag_o  out  1  OF captured by the last ALU command

Behaviour:
- Reset low: state=IDLE; latched rs/rt/rd/alu_op/type=0; ALU_OP=0; Write_Reg=0, Mem_Write=0, wr_data_s=00; done=0; flag_z=flag_o=0. Effect is immediate (async), including mid-command. The aborted command is not completed and produces no done.
- Handshake: a command is accepted at a rising edge when cmd_valid & cmd_ready. Fields are latched at that edge. cmd_valid while busy is ignored and the latched fields stay unchanged.
- States: IDLE, EXEC, MEM, WB. Binary encoded, registered.
- IDLE: cmd_ready=1; all strobes 0. On accept: ALU/LOAD/STORE go to EXEC; NOP stays in IDLE and sets done for the next cycle.
- EXEC (1 cycle): rs/rt = latched values; ALU_OP = latched alu_op for ALU type, ALU_ADD for LOAD/STORE.
  - ALU type: flag_z/flag_o <= ZF/OF at the edge leaving EXEC. LOAD/STORE leave the flags unchanged.
  - Next state: ALU -> WB; LOAD/STORE -> MEM.
- MEM (1 cycle): RAM address comes from F.
  - STORE: Mem_Write=1 for this cycle only, then IDLE with done.
  - LOAD: Mem_Write=0. The RAM read registers at the edge leaving MEM. Next state WB.
- WB (1 cycle): Write_Reg=1; rd = latched rd; wr_data_s=00 (ALU) or 01 (LOAD). Next state IDLE with done.
- rs, rt, ALU_OP hold constant from EXEC until the command ends, so F and the RAM address stay stable. They hold their last values in IDLE.
- rd, wr_data_s: rd holds its last value outside WB; wr_data_s=00 outside WB.
- done: registered, high for exactly the first IDLE cycle after completion. A new command may be accepted in that same cycle (zero-bubble back-to-back).
- Latency (accept edge = cycle 0): ALU done in cycle 3, LOAD in cycle 4, STORE in cycle 3, NOP in cycle 1.
- Write_Reg and Mem_Write are never high in the same cycle.
- Outputs are decoded from the state register plus latched fields only; there are no combinational paths from cmd_* to outputs.

Decomposition:
- Shared package: cmd_type codes (CMD_ALU/LOAD/STORE/NOP), state encodings, wr_data_s codes (WDS_ALU=00, WDS_MEM=01), ALU_ADD.
- No sub-module. This is a single FSM with its command latch, roughly 150-200 lines.

Test Plan:
- ALU: accept type 00, alu_op=100, rs=0, rt=1, rd=2; hold ZF=1, OF=0 in cycle 1 -> cycle 1: rs=0, rt=1, ALU_OP=100, no strobes; cycle 2: Write_Reg=1, rd=2, wr_data_s=00, flag_z=1; cycle 3: done=1, cmd_ready=1.
- LOAD: type 01, alu_op=000, rs=0, rt=1, rd=3 -> ALU_OP=100 in cycles 1-3; Write_Reg=1 with wr_data_s=01 only in cycle 3; done in cycle 4; flags unchanged.
- STORE: type 10, rs=2, rt=3 -> Mem_Write=1 only in cycle 2; Write_Reg never asserted; done in cycle 3; rs=2, rt=3 stable in cycles 1-2.
- Back-to-back and NOP: ALU then NOP with cmd_valid held -> second command accepted in the done cycle; NOP gives done exactly one cycle later with no strobes. cmd_valid with changed fields during busy -> ignored.
- Reset: drive Reset low in the middle of LOAD WB -> Write_Reg drops to 0 before the next edge; state=IDLE, cmd_ready=1, flags=0, no done. After release, a fresh ALU command completes normally.

Source files
------------

// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the datapath sequencer: command types, FSM states,
// write-data select codes and the ALU opcode used for address calculation.
package datapath_sequencer_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned OP_W_DEF   = 3;

  typedef enum logic [1:0] {
    CMD_ALU   = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_STORE = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_MEM  = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  localparam logic [1:0] WDS_ALU = 2'b00;
  localparam logic [1:0] WDS_MEM = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b100;

endpackage

// File: rtl/datapath_sequencer.sv
// Multi-cycle control sequencer for the regfile / ALU / RAM datapath.
// One command at a time; every control output is a flop updated at the edge.
module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [OP_W-1:0]   cmd_alu_op,
  input  logic [REG_AW-1:0] cmd_rs,
  input  logic [REG_AW-1:0] cmd_rt,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic              ZF,
  input  logic              OF,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [OP_W-1:0]   ALU_OP,
  output logic              Write_Reg,
  output logic              Mem_Write,
  output logic [1:0]        wr_data_s,
  output logic              done,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_o
);

  state_e              r_state;
  cmd_type_e           r_type;
  logic [REG_AW-1:0]   r_rd_lat;
  logic [REG_AW-1:0]   r_rs;
  logic [REG_AW-1:0]   r_rt;
  logic [REG_AW-1:0]   r_rd;
  logic [OP_W-1:0]     r_alu_op;
  logic                r_write_reg;
  logic                r_mem_write;
  logic [1:0]          r_wr_data_s;
  logic                r_done;
  logic                r_ready;
  logic                r_busy;
  logic                r_flag_z;
  logic                r_flag_o;
  cmd_type_e           w_cmd_type;

  assign w_cmd_type = cmd_type_e'(cmd_type);

  // Sequencer FSM; strobes and done default low and are re-asserted per state.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_type      <= CMD_ALU;
      r_rd_lat    <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_alu_op    <= '0;
      r_write_reg <= 1'b0;
      r_mem_write <= 1'b0;
      r_wr_data_s <= WDS_ALU;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_o    <= 1'b0;
    end else begin
      r_write_reg <= 1'b0;
      r_mem_write <= 1'b0;
      r_wr_data_s <= WDS_ALU;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_type   <= w_cmd_type;
            r_rd_lat <= cmd_rd;
            if (w_cmd_type == CMD_NOP) begin
              r_done <= 1'b1;
            end else begin
              // Operand addresses and opcode are set here so F is stable from EXEC on.
              r_rs     <= cmd_rs;
              r_rt     <= cmd_rt;
              r_alu_op <= (w_cmd_type == CMD_ALU) ? cmd_alu_op : OP_W'(ALU_ADD);
              r_state  <= ST_EXEC;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (r_type == CMD_ALU) begin
            r_flag_z    <= ZF;
            r_flag_o    <= OF;
            r_state     <= ST_WB;
            r_write_reg <= 1'b1;
            r_rd        <= r_rd_lat;
            r_wr_data_s <= WDS_ALU;
          end else begin
            r_state     <= ST_MEM;
            r_mem_write <= (r_type == CMD_STORE);
          end
        end
        ST_MEM: begin
          if (r_type == CMD_STORE) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state     <= ST_WB;
            r_write_reg <= 1'b1;
            r_rd        <= r_rd_lat;
            r_wr_data_s <= WDS_MEM;
          end
        end
        ST_WB: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign rs        = r_rs;
  assign rt        = r_rt;
  assign rd        = r_rd;
  assign ALU_OP    = r_alu_op;
  assign Write_Reg = r_write_reg;
  assign Mem_Write = r_mem_write;
  assign wr_data_s = r_wr_data_s;
  assign done      = r_done;
  assign flag_z    = r_flag_z;
  assign flag_o    = r_flag_o;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed and random commands
// compared cycle by cycle against a latency/schedule reference model.
module tb_datapath_sequencer;
  import datapath_sequencer_pkg::*;

  logic       clk;
  logic       Reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [2:0] cmd_alu_op;
  logic [4:0] cmd_rs, cmd_rt, cmd_rd;
  logic       ZF, OF;
  logic [4:0] rs, rt, rd;
  logic [2:0] ALU_OP;
  logic       Write_Reg, Mem_Write;
  logic [1:0] wr_data_s;
  logic       done, busy, flag_z, flag_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of values that persist between commands.
  logic [4:0] m_rs, m_rt, m_rd;
  logic [2:0] m_op;
  logic       m_fz, m_fo;

  datapath_sequencer dut (
    .clk(clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_alu_op(cmd_alu_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .ZF(ZF), .OF(OF),
    .rs(rs), .rt(rt), .rd(rd), .ALU_OP(ALU_OP),
    .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .wr_data_s(wr_data_s),
    .done(done), .busy(busy), .flag_z(flag_z), .flag_o(flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input bit e_rdy, input bit e_done,
                         input bit e_wreg, input bit e_mw, input logic [1:0] e_wds);
    chk({ph, ".cmd_ready"}, 32'(cmd_ready), 32'(e_rdy));
    chk({ph, ".busy"},      32'(busy),      32'(!e_rdy));
    chk({ph, ".done"},      32'(done),      32'(e_done));
    chk({ph, ".Write_Reg"}, 32'(Write_Reg), 32'(e_wreg));
    chk({ph, ".Mem_Write"}, 32'(Mem_Write), 32'(e_mw));
    chk({ph, ".wr_data_s"}, 32'(wr_data_s), 32'(e_wds));
    chk({ph, ".rs"},        32'(rs),        32'(m_rs));
    chk({ph, ".rt"},        32'(rt),        32'(m_rt));
    chk({ph, ".ALU_OP"},    32'(ALU_OP),    32'(m_op));
    chk({ph, ".rd"},        32'(rd),        32'(m_rd));
    chk({ph, ".flag_z"},    32'(flag_z),    32'(m_fz));
    chk({ph, ".flag_o"},    32'(flag_o),    32'(m_fo));
  endtask

  function automatic string cname(input cmd_type_e t);
    case (t)
      CMD_ALU:   return "alu";
      CMD_LOAD:  return "load";
      CMD_STORE: return "store";
      default:   return "nop";
    endcase
  endfunction

  // Offer one command in the current (ready) cycle and follow it to its done
  // cycle. zo is {ZF,OF} presented during the EXEC cycle; junk offers random
  // commands while busy; stop_at>0 returns early in that cycle.
  task automatic run_cmd(input cmd_type_e typ, input logic [2:0] op,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic [1:0] zo, input bit junk, input int stop_at);
    int lat;
    bit wb;
    lat = (typ == CMD_NOP) ? 1 : (typ == CMD_LOAD) ? 4 : 3;
    chk({cname(typ), ".ready_pre"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_type   = typ;
    cmd_alu_op = op;
    cmd_rs     = a;
    cmd_rt     = b;
    cmd_rd     = d;
    {ZF, OF}   = 2'($urandom);
    @(posedge clk); #1;
    if (typ != CMD_NOP) begin
      m_rs = a;
      m_rt = b;
      m_op = (typ == CMD_ALU) ? op : 3'b100;
    end
    for (int c = 1; c <= lat; c++) begin
      if (c == 1) {ZF, OF} = zo;
      else        {ZF, OF} = 2'($urandom);
      if (c == 2 && typ == CMD_ALU) {m_fz, m_fo} = zo;
      wb = (typ == CMD_ALU && c == 2) || (typ == CMD_LOAD && c == 3);
      if (wb) m_rd = d;
      chk_all($sformatf("%s.c%0d", cname(typ), c), c == lat, c == lat, wb,
              typ == CMD_STORE && c == 2,
              (typ == CMD_LOAD && c == 3) ? 2'b01 : 2'b00);
      if (c == stop_at) begin
        cmd_valid = 1'b0;
        return;
      end
      if (c < lat && junk) begin
        cmd_valid  = 1'b1;
        cmd_type   = 2'($urandom);
        cmd_alu_op = 3'($urandom);
        cmd_rs     = 5'($urandom);
        cmd_rt     = 5'($urandom);
        cmd_rd     = 5'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      if (c < lat) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      {ZF, OF} = 2'($urandom);
      @(posedge clk); #1;
      chk_all($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    end
  endtask

  initial begin
    Reset = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_alu_op = 3'b000;
    cmd_rs = 5'd0; cmd_rt = 5'd0; cmd_rd = 5'd0; ZF = 1'b0; OF = 1'b0;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_op = 3'd0; m_fz = 1'b0; m_fo = 1'b0;
    #12;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    Reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the plan
    run_cmd(CMD_ALU,   3'b100, 5'd0, 5'd1, 5'd2, 2'b10, 1'b0, 0);
    idle(1);
    run_cmd(CMD_LOAD,  3'b000, 5'd0, 5'd1, 5'd3, 2'b01, 1'b0, 0);
    idle(1);
    run_cmd(CMD_STORE, 3'b011, 5'd2, 5'd3, 5'd7, 2'b11, 1'b0, 0);
    // Back-to-back ALU then NOP with busy-time garbage offered
    run_cmd(CMD_ALU,   3'b010, 5'd9, 5'd10, 5'd11, 2'b01, 1'b1, 0);
    run_cmd(CMD_NOP,   3'b111, 5'd31, 5'd31, 5'd31, 2'b11, 1'b0, 0);
    run_cmd(CMD_NOP,   3'b101, 5'd17, 5'd18, 5'd19, 2'b00, 1'b0, 0);
    idle(2);

    // Random commands, mostly back-to-back, some idle gaps
    for (int i = 0; i < 60; i++) begin
      run_cmd(cmd_type_e'($urandom_range(0, 3)), 3'($urandom), 5'($urandom),
              5'($urandom), 5'($urandom), 2'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Async reset in the WB cycle of a LOAD, with both flags set beforehand
    run_cmd(CMD_ALU,  3'b001, 5'd4, 5'd5, 5'd6, 2'b11, 1'b0, 0);
    run_cmd(CMD_LOAD, 3'b110, 5'd7, 5'd8, 5'd12, 2'b00, 1'b0, 3);
    #2 Reset = 1'b0;
    #1;
    m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_op = 3'd0; m_fz = 1'b0; m_fo = 1'b0;
    chk_all("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    @(posedge clk); #1;
    chk_all("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    Reset = 1'b1;
    idle(1);
    run_cmd(CMD_ALU, 3'b011, 5'd13, 5'd14, 5'd15, 2'b10, 1'b0, 0);
    idle(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
